// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays jump, milestone and game-over tone sequences
// as a square wave, with priority preemption and per-tone durations counted
// in 60 Hz frame ticks.
module sfx_sequencer #(
  parameter int HP_JUMP  = 14000,
  parameter int HP_MS_A  = 9500,
  parameter int HP_MS_B  = 7100,
  parameter int HP_GO1   = 19000,
  parameter int HP_GO2   = 25000,
  parameter int HP_GO3   = 38000,
  parameter int DUR_JUMP = 6,
  parameter int DUR_MS   = 4,
  parameter int DUR_GO   = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick_60hz,
  input  logic i_jump_pulse,
  input  logic i_milestone_pulse,
  input  logic i_game_over_pulse,
  input  logic i_mute,
  output logic o_sound,
  output logic o_busy
);

  localparam int unsigned HP_W   = 16;
  localparam int unsigned TICK_W = 4;
  localparam int unsigned PRIO_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_JUMP,
    S_MS_A,
    S_MS_B,
    S_GO_1,
    S_GO_2,
    S_GO_3
  } state_e;

  state_e              state_q, state_d;
  logic [HP_W-1:0]     hp_cnt_q, hp_cnt_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                phase_q, phase_d;
  logic                sound_q, sound_d;

  logic                entry;
  logic [PRIO_W-1:0]   req_prio;
  logic [PRIO_W-1:0]   cur_prio;
  state_e              req_state;
  logic [TICK_W-1:0]   dur_lim;
  logic [HP_W-1:0]     hp_lim;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hp_cnt_q   <= '0;
      tick_cnt_q <= '0;
      phase_q    <= 1'b0;
      sound_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_cnt_q   <= hp_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      sound_q    <= sound_d;
    end
  end

  // Next state: accepted request wins over duration-expiry advance
  always_comb begin
    state_d   = state_q;
    entry     = 1'b0;
    req_prio  = '0;
    req_state = S_IDLE;
    cur_prio  = '0;
    dur_lim   = '0;

    if (i_game_over_pulse) begin
      req_prio  = PRIO_W'(3);
      req_state = S_GO_1;
    end else if (i_milestone_pulse) begin
      req_prio  = PRIO_W'(2);
      req_state = S_MS_A;
    end else if (i_jump_pulse) begin
      req_prio  = PRIO_W'(1);
      req_state = S_JUMP;
    end

    case (state_q)
      S_JUMP:                 begin cur_prio = PRIO_W'(1); dur_lim = TICK_W'(DUR_JUMP); end
      S_MS_A, S_MS_B:         begin cur_prio = PRIO_W'(2); dur_lim = TICK_W'(DUR_MS);   end
      S_GO_1, S_GO_2, S_GO_3: begin cur_prio = PRIO_W'(3); dur_lim = TICK_W'(DUR_GO);   end
      default:                begin cur_prio = '0;         dur_lim = '0;                end
    endcase

    if ((req_prio != '0) && (req_prio >= cur_prio)) begin
      state_d = req_state;
      entry   = 1'b1;
    end else if ((state_q != S_IDLE) && i_tick_60hz && (tick_cnt_q == dur_lim)) begin
      entry = 1'b1;
      case (state_q)
        S_MS_A:  state_d = S_MS_B;
        S_GO_1:  state_d = S_GO_2;
        S_GO_2:  state_d = S_GO_3;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Counters, square-wave phase and registered sound output
  always_comb begin
    hp_cnt_d   = hp_cnt_q;
    tick_cnt_d = tick_cnt_q;
    phase_d    = phase_q;
    sound_d    = phase_q & ~i_mute & (state_q != S_IDLE);

    case (state_q)
      S_JUMP:  hp_lim = HP_W'(HP_JUMP - 1);
      S_MS_A:  hp_lim = HP_W'(HP_MS_A - 1);
      S_MS_B:  hp_lim = HP_W'(HP_MS_B - 1);
      S_GO_1:  hp_lim = HP_W'(HP_GO1 - 1);
      S_GO_2:  hp_lim = HP_W'(HP_GO2 - 1);
      S_GO_3:  hp_lim = HP_W'(HP_GO3 - 1);
      default: hp_lim = '0;
    endcase

    if (entry || (state_q == S_IDLE)) begin
      hp_cnt_d   = '0;
      tick_cnt_d = '0;
      phase_d    = 1'b0;
    end else begin
      if (hp_cnt_q == hp_lim) begin
        hp_cnt_d = '0;
        phase_d  = ~phase_q;
      end else begin
        hp_cnt_d = hp_cnt_q + HP_W'(1);
      end
      if (i_tick_60hz) begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end
    end
  end

  assign o_sound = sound_q;
  assign o_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed testbench for sfx_sequencer with shortened tones; a frame tick
// arrives every 100 cycles, its phase re-aligned at the start of each test.
module tb_sfx_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic i_tick_60hz;
  logic i_jump_pulse;
  logic i_milestone_pulse;
  logic i_game_over_pulse;
  logic i_mute;
  logic o_sound;
  logic o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int tcnt    = 0;

  always #5 clk = ~clk;

  sfx_sequencer #(
    .HP_JUMP (4),
    .HP_MS_A (3),
    .HP_MS_B (2),
    .HP_GO1  (5),
    .HP_GO2  (6),
    .HP_GO3  (7),
    .DUR_JUMP(2),
    .DUR_MS  (1),
    .DUR_GO  (1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_tick_60hz      (i_tick_60hz),
    .i_jump_pulse     (i_jump_pulse),
    .i_milestone_pulse(i_milestone_pulse),
    .i_game_over_pulse(i_game_over_pulse),
    .i_mute           (i_mute),
    .o_sound          (o_sound),
    .o_busy           (o_busy)
  );

  // Advance one clock; pulses last one cycle, tick in every 100th cycle
  task automatic step();
    @(posedge clk);
    #1;
    i_jump_pulse      = 1'b0;
    i_milestone_pulse = 1'b0;
    i_game_over_pulse = 1'b0;
    tcnt              = (tcnt + 1) % 100;
    i_tick_60hz       = (tcnt == 99);
  endtask

  // Idle a little, then restart the tick phase so edge k samples tcnt==k%100
  task automatic sync_tb();
    step();
    step();
    tcnt        = 0;
    i_tick_60hz = 1'b0;
  endtask

  // Expected phase m cycles-edges after a tone entered at edge e
  function automatic logic ph(int m, int e, int h);
    return 1'(((m - e) / h) % 2);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    n_tests++;
    if (o_sound !== 1'b0) begin n_fail++; $display("FAIL reset_sound got %b exp 0", o_sound); end
    n_tests++;
    if (dut.hp_cnt_q !== 16'd0) begin n_fail++; $display("FAIL reset_hp got %0d exp 0", dut.hp_cnt_q); end
    n_tests++;
    if (dut.tick_cnt_q !== 4'd0) begin n_fail++; $display("FAIL reset_tick got %0d exp 0", dut.tick_cnt_q); end
    rst = 1'b0;
    step();
    n_tests++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b exp 0", o_busy); end
  endtask

  task automatic test_jump();
    logic eb, es;
    sync_tb();
    for (int k = 0; k <= 301; k++) begin
      i_jump_pulse = (k == 0);
      step();
      eb = (k < 299);
      es = (k >= 1 && k <= 299) ? ph(k - 1, 0, 4) : 1'b0;
      n_tests++;
      if (o_busy !== eb) begin n_fail++; $display("FAIL jump_busy k=%0d got %b exp %b", k, o_busy, eb); end
      n_tests++;
      if (o_sound !== es) begin n_fail++; $display("FAIL jump_sound k=%0d got %b exp %b", k, o_sound, es); end
    end
  endtask

  task automatic test_game_over();
    logic eb, es;
    int m;
    sync_tb();
    for (int k = 0; k <= 601; k++) begin
      i_game_over_pulse = (k == 0);
      step();
      m  = k - 1;
      eb = (k < 599);
      if (k < 1)        es = 1'b0;
      else if (m <= 198) es = ph(m, 0, 5);
      else if (m <= 398) es = ph(m, 199, 6);
      else if (m <= 598) es = ph(m, 399, 7);
      else               es = 1'b0;
      n_tests++;
      if (o_busy !== eb) begin n_fail++; $display("FAIL go_busy k=%0d got %b exp %b", k, o_busy, eb); end
      n_tests++;
      if (o_sound !== es) begin n_fail++; $display("FAIL go_sound k=%0d got %b exp %b", k, o_sound, es); end
    end
  endtask

  task automatic test_preempt();
    logic eb, es;
    int m;
    sync_tb();
    for (int k = 0; k <= 401; k++) begin
      i_jump_pulse      = (k == 0) || (k == 250);
      i_milestone_pulse = (k == 30);
      step();
      m  = k - 1;
      eb = (k < 399);
      if (k < 1)         es = 1'b0;
      else if (m <= 29)  es = ph(m, 0, 4);
      else if (m <= 198) es = ph(m, 30, 3);
      else if (m <= 398) es = ph(m, 199, 2);
      else               es = 1'b0;
      n_tests++;
      if (o_busy !== eb) begin n_fail++; $display("FAIL preempt_busy k=%0d got %b exp %b", k, o_busy, eb); end
      n_tests++;
      if (o_sound !== es) begin n_fail++; $display("FAIL preempt_sound k=%0d got %b exp %b", k, o_sound, es); end
      if (k == 30) begin
        n_tests++;
        if (dut.hp_cnt_q !== 16'd0) begin n_fail++; $display("FAIL preempt_hp_clr got %0d exp 0", dut.hp_cnt_q); end
        n_tests++;
        if (dut.tick_cnt_q !== 4'd0) begin n_fail++; $display("FAIL preempt_tick_clr got %0d exp 0", dut.tick_cnt_q); end
      end
    end
  endtask

  task automatic test_simul();
    logic eb, es;
    int m;
    sync_tb();
    for (int k = 0; k <= 901; k++) begin
      i_jump_pulse      = (k == 0);
      i_milestone_pulse = (k == 0);
      i_game_over_pulse = (k == 0) || (k == 320);
      step();
      m  = k - 1;
      eb = (k < 899);
      if (k < 1)         es = 1'b0;
      else if (m <= 198) es = ph(m, 0, 5);
      else if (m <= 319) es = ph(m, 199, 6);
      else if (m <= 498) es = ph(m, 320, 5);
      else if (m <= 698) es = ph(m, 499, 6);
      else if (m <= 898) es = ph(m, 699, 7);
      else               es = 1'b0;
      n_tests++;
      if (o_busy !== eb) begin n_fail++; $display("FAIL simul_busy k=%0d got %b exp %b", k, o_busy, eb); end
      n_tests++;
      if (o_sound !== es) begin n_fail++; $display("FAIL simul_sound k=%0d got %b exp %b", k, o_sound, es); end
      if (k == 319) begin
        n_tests++;
        if (dut.tick_cnt_q !== 4'd1) begin n_fail++; $display("FAIL simul_tick_before got %0d exp 1", dut.tick_cnt_q); end
      end
      if (k == 320) begin
        n_tests++;
        if (dut.tick_cnt_q !== 4'd0) begin n_fail++; $display("FAIL simul_tick_restart got %0d exp 0", dut.tick_cnt_q); end
      end
    end
  endtask

  task automatic test_mute();
    logic eb, es, mute_k;
    for (int p = 0; p < 2; p++) begin
      sync_tb();
      for (int k = 0; k <= 301; k++) begin
        mute_k       = (p == 0) ? 1'b1 : (k < 100);
        i_mute       = mute_k;
        i_jump_pulse = (k == 0);
        step();
        eb = (k < 299);
        es = (k >= 1 && k <= 299) ? (ph(k - 1, 0, 4) & ~mute_k) : 1'b0;
        n_tests++;
        if (o_busy !== eb) begin n_fail++; $display("FAIL mute_busy p=%0d k=%0d got %b exp %b", p, k, o_busy, eb); end
        n_tests++;
        if (o_sound !== es) begin n_fail++; $display("FAIL mute_sound p=%0d k=%0d got %b exp %b", p, k, o_sound, es); end
      end
    end
    i_mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic eb, es;
    int m;
    sync_tb();
    for (int k = 0; k <= 510; k++) begin
      i_game_over_pulse = (k == 0);
      i_jump_pulse      = (k == 250) || (k == 251);
      rst               = (k == 250);
      step();
      rst = 1'b0;
      m   = k - 1;
      if (k < 250)       eb = 1'b1;
      else if (k == 250) eb = 1'b0;
      else               eb = (k < 499);
      if (k < 1)                   es = 1'b0;
      else if (m <= 198)           es = ph(m, 0, 5);
      else if (m <= 248)           es = ph(m, 199, 6);
      else if (m <= 250)           es = 1'b0;
      else if (m <= 498)           es = ph(m, 251, 4);
      else                         es = 1'b0;
      n_tests++;
      if (o_busy !== eb) begin n_fail++; $display("FAIL rstmid_busy k=%0d got %b exp %b", k, o_busy, eb); end
      n_tests++;
      if (o_sound !== es) begin n_fail++; $display("FAIL rstmid_sound k=%0d got %b exp %b", k, o_sound, es); end
    end
  endtask

  initial begin
    rst               = 1'b1;
    i_tick_60hz       = 1'b0;
    i_jump_pulse      = 1'b0;
    i_milestone_pulse = 1'b0;
    i_game_over_pulse = 1'b0;
    i_mute            = 1'b0;
    test_reset();
    test_jump();
    test_game_over();
    test_preempt();
    test_simul();
    test_mute();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sfx_sequencer.md
SFX_SEQUENCER -- requirements
Module: sfx_sequencer

Interface
REQ-001 SHALL have parameter HP_JUMP, default 14000: jump tone half-period, in clk cycles.
REQ-002 SHALL have parameter HP_MS_A, default 9500; HP_MS_B, default 7100: milestone tone A and tone B half-periods.
REQ-003 SHALL have parameters HP_GO1, default 19000; HP_GO2, default 25000; HP_GO3, default 38000: game-over tone half-periods.
REQ-004 SHALL have parameters DUR_JUMP, default 6; DUR_MS, default 4; DUR_GO, default 10: per-tone duration, in 60 Hz ticks.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 Ports SHALL be as follows.
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- i_tick_60hz  input  1  one-cycle frame tick.
- i_jump_pulse  input  1  one-cycle jump request.
- i_milestone_pulse  input  1  one-cycle score-milestone request.
- i_game_over_pulse  input  1  one-cycle game-over request.
- i_mute  input  1  level; silences output.
- o_sound  output  1  registered square wave.
- o_busy  output  1  high whenever state is not IDLE.

Function
REQ-007 States SHALL be IDLE, JUMP, MS_A, MS_B, GO_1, GO_2, GO_3.
REQ-008 Request priority SHALL be game_over > milestone > jump; when several pulses arrive in one cycle, only the highest is taken.
REQ-009 A request SHALL be accepted in the following cases:
- in IDLE;
- when it has higher priority than the sound now playing (preempt);
- when it has the same priority (restart at the first tone of that sound).
REQ-010 A request of lower priority than the sound now playing SHALL be dropped, with no queueing.
REQ-011 Each accepted request SHALL take effect on the next clk edge: the first tone state is entered (JUMP, MS_A or GO_1).
REQ-012 On every state entry, the following SHALL be cleared: the half-period counter, the tick counter, and the internal square-wave phase (phase = 0).
REQ-013 In any non-IDLE state, the half-period counter (16 bits) SHALL increment each cycle.
REQ-014 When the half-period counter equals HP_x-1, the phase SHALL toggle and the counter SHALL return to 0.
REQ-015 The tick counter (4 bits) SHALL increment on i_tick_60hz, except that a tick in the same cycle as a state entry is ignored.
REQ-016 When the tick counter reaches DUR_x and a tick arrives, the state SHALL advance one step:
- JUMP->IDLE;
- MS_A->MS_B->IDLE;
- GO_1->GO_2->GO_3->IDLE.
REQ-017 The nominal length of each tone SHALL be DUR_x+1 ticks after entry (first tick ignored).
REQ-018 An accepted request SHALL override a duration-expiry advance that occurs in the same cycle.
REQ-019 o_sound SHALL be registered and equal to phase & ~i_mute & (state != IDLE), one cycle after the internal terms.
REQ-020 i_mute SHALL NOT affect sequencing, counters or o_busy.
REQ-021 o_busy SHALL be combinational from the state register.
REQ-022 In IDLE the counters SHALL hold at 0 and phase SHALL be 0.
REQ-023 Parameters with HP_x < 2 or DUR_x > 14 are unsupported; the behaviour is undefined.

Reset
REQ-024 While rst is high at a clk edge, the block SHALL set state=IDLE, both counters=0, phase=0 and o_sound=0; o_busy reads 0.
REQ-025 Reset mid-sound SHALL abort the sound, and no residual request SHALL be remembered.
REQ-026 Pulses present in the cycle of rst release SHALL be ignored; pulses from the following cycle onward SHALL be accepted.

Verification
(Bench overrides: HP_JUMP=4, HP_MS_A=3, HP_MS_B=2, HP_GO1=5, HP_GO2=6, HP_GO3=7, DUR_JUMP=2, DUR_MS=1, DUR_GO=1; tick every 100 cycles.)
REQ-027 Jump: single i_jump_pulse in IDLE -> o_busy=1 on the next cycle; o_sound toggles every 4 cycles, first rising 5 cycles after the pulse; back to IDLE on the 3rd tick after entry; o_sound=0 one cycle later.
REQ-028 Full game-over sequence: i_game_over_pulse -> GO_1 (period 10 cycles), GO_2 (period 12), GO_3 (period 14), each lasting 2 ticks; then IDLE with o_busy=0.
REQ-029 Preemption: i_jump_pulse, then i_milestone_pulse 30 cycles later -> MS_A entered and counters cleared; a later i_jump_pulse during MS_B is dropped and MS_B completes.
REQ-030 Simultaneous requests: all three pulses in one cycle -> GO_1 only; restart by a second i_game_over_pulse during GO_2 -> back to GO_1 with tick count 0.
REQ-031 Mute: i_mute=1 throughout a jump sound -> o_sound stays 0, o_busy timing unchanged; mute released mid-tone -> o_sound resumes following phase.
REQ-032 Reset: rst asserted for 1 cycle during GO_2 -> IDLE, o_sound=0, o_busy=0; a jump pulse in the release cycle is ignored, and one the cycle after starts JUMP.
